// File: rtl/uart_pkg.sv
// Shared UART constants: baud_set codes, TX divisors, frame lengths and a bit-select helper.
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int unsigned DIV_W = 13;

    // Divisors assume a 50 MHz clock; one bit lasts divisor+1 cycles.
    localparam logic [DIV_W-1:0] DIV_9600   = 13'd5207;
    localparam logic [DIV_W-1:0] DIV_19200  = 13'd2603;
    localparam logic [DIV_W-1:0] DIV_38400  = 13'd1301;
    localparam logic [DIV_W-1:0] DIV_57600  = 13'd867;
    localparam logic [DIV_W-1:0] DIV_115200 = 13'd433;

    localparam logic [3:0] FRAME_BITS_1STOP = 4'd10;
    localparam logic [3:0] FRAME_BITS_2STOP = 4'd11;

    typedef enum logic {StIdle, StBusy} tx_state_e;

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            BAUD_19200:  return DIV_19200;
            BAUD_38400:  return DIV_38400;
            BAUD_57600:  return DIV_57600;
            BAUD_115200: return DIV_115200;
            default:     return DIV_9600;
        endcase
    endfunction

    // Line level for frame bit idx: start, eight data bits LSB first, then stop bit(s).
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [3:0] sel;
        sel = idx - 4'd1;
        if (idx == 4'd0) begin
            return 1'b0;
        end else if (idx <= 4'd8) begin
            return data[sel[2:0]];
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// Bit-period divider: counts 0..bps_dr while enabled and flags the wrap cycle with bit_end_o.
`timescale 1ns/1ps
module uart_bps_gen
    import uart_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] bps_dr_i,
    output logic             bit_end_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign bit_end_o = en_i && (div_cnt_q == bps_dr_i);

    always_comb begin
        div_cnt_d = div_cnt_q + 13'd1;
        if (!en_i || bit_end_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter; define UART_TX_STOP2_EN to send two stop bits per frame.
`timescale 1ns/1ps
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_set,
    input  logic [7:0] data_byte,
    input  logic       Send_En,
    output logic       Rs232_Tx,
    output logic       Tx_Done,
    output logic       uart_state
);

`ifdef UART_TX_STOP2_EN
    localparam logic [3:0] LAST_BIT = FRAME_BITS_2STOP - 4'd1;
`else
    localparam logic [3:0] LAST_BIT = FRAME_BITS_1STOP - 4'd1;
`endif

    if (CLK_FREQ != 50_000_000) begin : g_clk_check
        $warning("uart_byte_tx divisors assume a 50 MHz clock");
    end

    tx_state_e        state_q;
    logic [3:0]       bit_idx_q;
    logic [3:0]       bit_idx_d;
    logic [7:0]       data_q;
    logic [DIV_W-1:0] bps_dr_q;
    logic             tx_q;
    logic             done_q;
    logic             bit_end;

    assign bit_idx_d = bit_idx_q + 4'd1;

    uart_bps_gen u_bps_gen (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .en_i      (state_q == StBusy),
        .bps_dr_i  (bps_dr_q),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            data_q    <= '0;
            bps_dr_q  <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Start bit goes out on the accepting edge itself.
                    if (Send_En) begin
                        state_q   <= StBusy;
                        data_q    <= data_byte;
                        bps_dr_q  <= baud_div(baud_set);
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                    end
                end
                StBusy: begin
                    if (bit_end) begin
                        if (bit_idx_q == LAST_BIT) begin
                            state_q   <= StIdle;
                            bit_idx_q <= '0;
                            tx_q      <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            tx_q      <= frame_bit(data_q, bit_idx_d);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Rs232_Tx   = tx_q;
    assign Tx_Done    = done_q;
    assign uart_state = (state_q == StBusy);

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: per-cycle line/state/done checks against a frame model.
`timescale 1ns/1ps
module tb_uart_byte_tx;

`ifdef UART_TX_STOP2_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [2:0] baud_set = 3'd0;
    logic [7:0] data_byte = 8'h00;
    logic       Send_En = 1'b0;
    logic       Rs232_Tx;
    logic       Tx_Done;
    logic       uart_state;

    int total = 0;
    int bad   = 0;

    uart_byte_tx #(.CLK_FREQ(50_000_000)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .Send_En    (Send_En),
        .Rs232_Tx   (Rs232_Tx),
        .Tx_Done    (Tx_Done),
        .uart_state (uart_state)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        return 1'b1;
    endfunction

    // Called at a negedge; request is taken on the next posedge, then inputs are scrambled
    // to show the frame uses only the latched copies.
    task automatic start(input logic [7:0] d, input logic [2:0] b);
        Send_En   = 1'b1;
        data_byte = d;
        baud_set  = b;
        @(posedge Clk);
        @(negedge Clk);
        Send_En   = 1'b0;
        data_byte = ~d;
        baud_set  = b ^ 3'd1;
    endtask

    // Entered at the negedge after t0; leaves at the negedge of the Tx_Done cycle
    // (or right after an abort). Checks {Rs232_Tx, uart_state, Tx_Done} every cycle.
    task automatic check_frame(input logic [7:0] d, input int p, input int inj_at,
                               input logic [7:0] inj_d, input int abort_at);
        logic [2:0] exp;
        for (int k = 0; k < NBITS * p; k++) begin
            if (k == abort_at) begin
                Rst = 1'b1;
                #1;
                chk("abort_now", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);
                @(negedge Clk);
                Rst = 1'b0;
                chk("abort_after", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);
                return;
            end
            if (k == inj_at) begin
                Send_En   = 1'b1;
                data_byte = inj_d;
            end else begin
                Send_En = 1'b0;
            end
            exp = {fbit(d, k / p), 1'b1, 1'b0};
            chk("frame_bit", {Rs232_Tx, uart_state, Tx_Done}, exp);
            @(negedge Clk);
        end
        chk("frame_done", {Rs232_Tx, uart_state, Tx_Done}, 3'b101);
    endtask

    task automatic idle_after_done();
        @(negedge Clk);
        chk("post_done_idle", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);
    endtask

    initial begin
        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("reset", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);
        end
        Rst = 1'b0;
        @(negedge Clk);
        chk("idle", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);

        // Single byte at 115200 (P=434)
        start(8'hA5, 3'd4);
        check_frame(8'hA5, 434, -1, 8'h00, -1);
        idle_after_done();

        // Busy rejection: second request 1000 cycles into the frame
        start(8'h3C, 3'd4);
        check_frame(8'h3C, 434, 999, 8'hFF, -1);
        idle_after_done();
        repeat (3) begin
            @(negedge Clk);
            chk("no_queued_frame", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);
        end

        // Back-to-back with rate change: 9600 then 38400 requested in the Tx_Done cycle
        start(8'h00, 3'd0);
        check_frame(8'h00, 5208, -1, 8'h00, -1);
        start(8'hFF, 3'd2);
        check_frame(8'hFF, 1302, -1, 8'h00, -1);
        idle_after_done();

        // Reset mid-frame, then a fresh frame
        start(8'hC3, 3'd4);
        check_frame(8'hC3, 434, -1, 8'h00, 1999);
        repeat (2) begin
            @(negedge Clk);
            chk("after_abort_idle", {Rs232_Tx, uart_state, Tx_Done}, 3'b100);
        end
        start(8'h55, 3'd4);
        check_frame(8'h55, 434, -1, 8'h00, -1);
        idle_after_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
